// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access type codes, FSM states,
// captured command payload and decode helpers.
package mem_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   typedef enum logic [3:0] {
      SL_NONE = 4'd0,
      SL_LB   = 4'd1,
      SL_LH   = 4'd2,
      SL_LW   = 4'd3,
      SL_LBU  = 4'd4,
      SL_LHU  = 4'd5,
      SL_SB   = 4'd6,
      SL_SH   = 4'd7,
      SL_SW   = 4'd8
   } sl_type_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic            we;
      sl_type_e        sl_type;
      logic [XLEN-1:0] addr;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } lsu_cmd_t;

   function automatic logic is_load(input sl_type_e t);
      return (t == SL_LB) || (t == SL_LH) || (t == SL_LW) || (t == SL_LBU) || (t == SL_LHU);
   endfunction

   function automatic logic is_store(input sl_type_e t);
      return (t == SL_SB) || (t == SL_SH) || (t == SL_SW);
   endfunction

   function automatic logic is_half(input sl_type_e t);
      return (t == SL_LH) || (t == SL_LHU) || (t == SL_SH);
   endfunction

   function automatic logic is_word(input sl_type_e t);
      return (t == SL_LW) || (t == SL_SW);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module mem_load_align
   import mem_pkg::*;
(
   input  sl_type_e        sl_type,
   input  logic [1:0]      byte_off,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] load_data_c
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = rdata >> {byte_off, 3'b000};
      case (sl_type)
         SL_LB:   load_data_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         SL_LBU:  load_data_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
         SL_LH:   load_data_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         SL_LHU:  load_data_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_data_c = rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: request/grant/response data bus master with pipeline stall.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking the low address bits.
module mem_lsu
   import mem_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid_mem_i,
   input  logic            dram_we_mem_i,
   input  logic [3:0]      sl_type_mem_i,
   input  logic [XLEN-1:0] alu_result_mem_i,
   input  logic [XLEN-1:0] rD2_mem_i,
   output logic            dram_req_o,
   output logic            dram_we_o,
   output logic [XLEN-1:0] dram_addr_o,
   output logic [BE_W-1:0] dram_be_o,
   output logic [XLEN-1:0] dram_wdata_o,
   input  logic            dram_gnt_i,
   input  logic            dram_rvalid_i,
   input  logic [XLEN-1:0] dram_rdata_i,
   output logic            mem_stall_o,
   output logic [XLEN-1:0] load_data_o,
   output logic            load_valid_o,
   output logic            misalign_o
);

   lsu_state_e      state_q, state_d;
   lsu_cmd_t        cmd_q, cmd_d;
   sl_type_e        ty_c;
   logic            access_c;
   logic            misalign_c;
   logic            req_d, load_valid_d, misalign_d;
   logic [XLEN-1:0] load_data_c;

   // Decode the EX/MEM command and build the bus payload
   always_comb begin
      ty_c          = sl_type_e'(sl_type_mem_i);
      access_c      = instr_valid_mem_i && (dram_we_mem_i ? is_store(ty_c) : is_load(ty_c));
      cmd_d         = '0;
      cmd_d.we      = dram_we_mem_i;
      cmd_d.sl_type = ty_c;
      cmd_d.addr    = alu_result_mem_i;
      if (is_half(ty_c)) cmd_d.addr[0] = 1'b0;
      if (is_word(ty_c)) cmd_d.addr[1:0] = 2'b00;
      if (is_word(ty_c))      cmd_d.be = '1;
      else if (is_half(ty_c)) cmd_d.be = cmd_d.addr[1] ? 4'b1100 : 4'b0011;
      else                    cmd_d.be = BE_W'(1) << cmd_d.addr[1:0];
      if (dram_we_mem_i) begin
         case (ty_c)
            SL_SB:   cmd_d.wdata = {4{rD2_mem_i[7:0]}};
            SL_SH:   cmd_d.wdata = {2{rD2_mem_i[15:0]}};
            SL_SW:   cmd_d.wdata = rD2_mem_i;
            default: cmd_d.wdata = '0;
         endcase
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_c = (is_half(ty_c) && alu_result_mem_i[0]) ||
                       (is_word(ty_c) && (alu_result_mem_i[1:0] != 2'b00));
`else
   assign misalign_c = 1'b0;
`endif

   // Next-state, stall and registered-output next values
   always_comb begin
      state_d      = state_q;
      req_d        = 1'b0;
      load_valid_d = 1'b0;
      misalign_d   = 1'b0;
      mem_stall_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (access_c) begin
               mem_stall_o = 1'b1;
               if (misalign_c) begin
                  state_d    = DONE;
                  misalign_d = 1'b1;
               end else begin
                  state_d = REQ;
                  req_d   = 1'b1;
               end
            end
         end
         REQ: begin
            mem_stall_o = 1'b1;
            if (dram_gnt_i) state_d = cmd_q.we ? DONE : WAIT_R;
            else            req_d   = 1'b1;
         end
         WAIT_R: begin
            mem_stall_o = 1'b1;
            if (dram_rvalid_i) begin
               state_d      = DONE;
               load_valid_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         dram_req_o   <= 1'b0;
         load_valid_o <= 1'b0;
         misalign_o   <= 1'b0;
         load_data_o  <= '0;
      end else begin
         state_q      <= state_d;
         dram_req_o   <= req_d;
         load_valid_o <= load_valid_d;
         misalign_o   <= misalign_d;
         if (state_q == IDLE && access_c && !misalign_c) cmd_q <= cmd_d;
         if (load_valid_d) load_data_o <= load_data_c;
      end
   end

   assign dram_we_o    = cmd_q.we;
   assign dram_addr_o  = {cmd_q.addr[XLEN-1:2], 2'b00};
   assign dram_be_o    = cmd_q.be;
   assign dram_wdata_o = cmd_q.wdata;

   mem_load_align u_align (
      .sl_type     (cmd_q.sl_type),
      .byte_off    (cmd_q.addr[1:0]),
      .rdata       (dram_rdata_i),
      .load_data_c (load_data_c)
   );

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a bus responder with programmable grant/rvalid latency
// and a scoreboard queue of expected load results.
module tb_mem_lsu;
   import mem_pkg::*;

   logic        clk, rst_n;
   logic        instr_valid_mem_i, dram_we_mem_i;
   logic [3:0]  sl_type_mem_i;
   logic [31:0] alu_result_mem_i, rD2_mem_i;
   logic        dram_req_o, dram_we_o;
   logic [31:0] dram_addr_o, dram_wdata_o;
   logic [3:0]  dram_be_o;
   logic        dram_gnt_i, dram_rvalid_i;
   logic [31:0] dram_rdata_i;
   logic        mem_stall_o, load_valid_o, misalign_o;
   logic [31:0] load_data_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] last_ld;

   int          obs_stall, obs_req, obs_lv, obs_mis;
   logic        obs_stable, obs_we, obs_to;
   logic [31:0] obs_addr, obs_wdata, obs_ld;
   logic [3:0]  obs_be;

   mem_lsu dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .instr_valid_mem_i (instr_valid_mem_i),
      .dram_we_mem_i     (dram_we_mem_i),
      .sl_type_mem_i     (sl_type_mem_i),
      .alu_result_mem_i  (alu_result_mem_i),
      .rD2_mem_i         (rD2_mem_i),
      .dram_req_o        (dram_req_o),
      .dram_we_o         (dram_we_o),
      .dram_addr_o       (dram_addr_o),
      .dram_be_o         (dram_be_o),
      .dram_wdata_o      (dram_wdata_o),
      .dram_gnt_i        (dram_gnt_i),
      .dram_rvalid_i     (dram_rvalid_i),
      .dram_rdata_i      (dram_rdata_i),
      .mem_stall_o       (mem_stall_o),
      .load_data_o       (load_data_o),
      .load_valid_o      (load_valid_o),
      .misalign_o        (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one instruction (entered at posedge+1) and play the memory side until the stall drops.
   task automatic do_access(input logic v, input logic we, input logic [3:0] ty,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                            input int gnt_wait, input int rv_wait, input int trail);
      int w;
      logic granted;
      obs_stall = 0; obs_req = 0; obs_lv = 0; obs_mis = 0;
      obs_stable = 1'b1; obs_to = 1'b1; obs_ld = 'x;
      obs_addr = 'x; obs_be = 'x; obs_wdata = 'x; obs_we = 'x;
      granted = 1'b0; w = 0;
      instr_valid_mem_i = v; dram_we_mem_i = we; sl_type_mem_i = ty;
      alu_result_mem_i = addr; rD2_mem_i = wd;
      for (int c = 0; c < 64; c++) begin
         #1;
         dram_gnt_i = 1'b0; dram_rvalid_i = 1'b0; dram_rdata_i = '0;
         if (mem_stall_o)  obs_stall++;
         if (misalign_o)   obs_mis++;
         if (load_valid_o) begin obs_lv++; obs_ld = load_data_o; end
         if (dram_req_o) begin
            if (obs_req == 0) begin
               obs_addr = dram_addr_o; obs_be = dram_be_o; obs_wdata = dram_wdata_o; obs_we = dram_we_o;
            end else if (dram_addr_o !== obs_addr || dram_be_o !== obs_be ||
                         dram_wdata_o !== obs_wdata || dram_we_o !== obs_we) begin
               obs_stable = 1'b0;
            end
            obs_req++;
         end
         if (!mem_stall_o) begin obs_to = 1'b0; break; end
         if (dram_req_o && obs_req == gnt_wait + 1) begin
            dram_gnt_i = 1'b1; granted = 1'b1; w = 0;
         end else if (granted && !dram_req_o) begin
            w++;
            if (w == rv_wait) begin dram_rvalid_i = 1'b1; dram_rdata_i = rd; end
         end
         @(posedge clk); #1;
      end
      dram_gnt_i = 1'b0; dram_rvalid_i = 1'b0;
      @(posedge clk); #1;
      if (trail > 0) begin
         instr_valid_mem_i = 1'b0; dram_we_mem_i = 1'b0; sl_type_mem_i = '0;
         for (int t = 0; t < trail; t++) begin
            #1;
            if (mem_stall_o)  obs_stall++;
            if (misalign_o)   obs_mis++;
            if (load_valid_o) obs_lv++;
            if (dram_req_o)   obs_req++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      logic [104:0] all_out;
      #1;
      all_out = {dram_req_o, dram_we_o, dram_addr_o, dram_be_o, dram_wdata_o,
                 mem_stall_o, load_data_o, load_valid_o, misalign_o};
      n_assert++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_assert++; if (mem_stall_o !== 1'b0 || dram_req_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: stall %b req %b want 0 0", mem_stall_o, dram_req_o);
      end
   endtask

   task automatic test_store();
      logic [3:0]  tys [3] = '{SL_SW, SL_SB, SL_SH};
      logic [31:0] adr [3] = '{32'h100, 32'h103, 32'h102};
      logic [31:0] wds [3] = '{32'hDEADBEEF, 32'h000000A5, 32'h1234BEEF};
      logic [3:0]  ebe [3] = '{4'b1111, 4'b1000, 4'b1100};
      logic [31:0] ewd [3] = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hBEEFBEEF};
      for (int i = 0; i < 3; i++) begin
         do_access(1'b1, 1'b1, tys[i], adr[i], wds[i], 32'h0, 0, 1, 2);
         n_assert++; if (obs_to !== 1'b0) begin n_fail++; $display("FAIL store[%0d] timeout: got %b want 0", i, obs_to); end
         n_assert++; if (obs_req !== 1) begin n_fail++; $display("FAIL store[%0d] req_cycles: got %0d want 1", i, obs_req); end
         n_assert++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL store[%0d] addr: got %h want 00000100", i, obs_addr); end
         n_assert++; if (obs_be !== ebe[i]) begin n_fail++; $display("FAIL store[%0d] be: got %b want %b", i, obs_be, ebe[i]); end
         n_assert++; if (obs_wdata !== ewd[i]) begin n_fail++; $display("FAIL store[%0d] wdata: got %h want %h", i, obs_wdata, ewd[i]); end
         n_assert++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL store[%0d] we: got %b want 1", i, obs_we); end
         n_assert++; if (obs_stall !== 2) begin n_fail++; $display("FAIL store[%0d] stall: got %0d want 2", i, obs_stall); end
         n_assert++; if (obs_lv !== 0) begin n_fail++; $display("FAIL store[%0d] load_valid: got %0d want 0", i, obs_lv); end
      end
   endtask

   task automatic test_load();
      logic [3:0]  tys [5] = '{SL_LB, SL_LBU, SL_LHU, SL_LH, SL_LW};
      logic [31:0] adr [5] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h104};
      logic [31:0] rds [5] = '{32'h12F03456, 32'h12F03456, 32'h12F03456, 32'h00008001, 32'h89ABCDEF};
      logic [31:0] exd [5] = '{32'hFFFFFFF0, 32'h000000F0, 32'h000012F0, 32'hFFFF8001, 32'h89ABCDEF};
      logic [3:0]  ebe [5] = '{4'b0100, 4'b0100, 4'b1100, 4'b0011, 4'b1111};
      logic [31:0] eadr[5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
      logic [31:0] e;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(exd[i]);
         do_access(1'b1, 1'b0, tys[i], adr[i], 32'hFFFFFFFF, rds[i], 0, 1, 2);
         n_assert++; if (obs_to !== 1'b0) begin n_fail++; $display("FAIL load[%0d] timeout: got %b want 0", i, obs_to); end
         n_assert++; if (obs_addr !== eadr[i] || obs_be !== ebe[i] || obs_we !== 1'b0 || obs_wdata !== 32'h0) begin
            n_fail++; $display("FAIL load[%0d] bus: got %h/%b/%b/%h want %h/%b/0/00000000", i, obs_addr, obs_be, obs_we, obs_wdata, eadr[i], ebe[i]);
         end
         n_assert++; if (obs_stall !== 3) begin n_fail++; $display("FAIL load[%0d] stall: got %0d want 3", i, obs_stall); end
         n_assert++; if (obs_lv !== 1) begin n_fail++; $display("FAIL load[%0d] load_valid_pulses: got %0d want 1", i, obs_lv); end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++; if (obs_ld !== e) begin n_fail++; $display("FAIL load[%0d] data: got %h want %h", i, obs_ld, e); end
            last_ld = e;
         end
      end
   endtask

   task automatic test_slow_load();
      logic [31:0] e;
      exp_q.push_back(32'h0BADF00D);
      do_access(1'b1, 1'b0, SL_LW, 32'h200, 32'h0, 32'h0BADF00D, 2, 2, 2);
      n_assert++; if (obs_to !== 1'b0) begin n_fail++; $display("FAIL slow timeout: got %b want 0", obs_to); end
      n_assert++; if (obs_stall !== 6) begin n_fail++; $display("FAIL slow stall: got %0d want 6", obs_stall); end
      n_assert++; if (obs_req !== 3) begin n_fail++; $display("FAIL slow req_cycles: got %0d want 3", obs_req); end
      n_assert++; if (obs_stable !== 1'b1 || obs_addr !== 32'h200) begin
         n_fail++; $display("FAIL slow req_stable: stable %b addr %h want 1 00000200", obs_stable, obs_addr);
      end
      n_assert++; if (obs_lv !== 1) begin n_fail++; $display("FAIL slow load_valid_pulses: got %0d want 1", obs_lv); end
      e = exp_q.pop_front();
      n_assert++; if (obs_ld !== e) begin n_fail++; $display("FAIL slow data: got %h want %h", obs_ld, e); end
      last_ld = e;
   endtask

   task automatic test_noop();
      logic       vs  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       wes [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [3:0] tys [5] = '{SL_LB, SL_SW, 4'd9, SL_SW, SL_NONE};
      for (int i = 0; i < 5; i++) begin
         do_access(vs[i], wes[i], tys[i], 32'h104, 32'h55, 32'h0, 0, 1, 2);
         n_assert++; if (obs_stall !== 0 || obs_req !== 0 || obs_lv !== 0 || obs_to !== 1'b0) begin
            n_fail++; $display("FAIL noop[%0d]: stall %0d req %0d lv %0d to %b want 0 0 0 0", i, obs_stall, obs_req, obs_lv, obs_to);
         end
      end
      n_assert++; if (load_data_o !== last_ld) begin n_fail++; $display("FAIL noop load_data_hold: got %h want %h", load_data_o, last_ld); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      exp_q.push_back(32'hFFFFFF80);
      exp_q.push_back(32'h0000BEEF);
      do_access(1'b1, 1'b1, SL_SW, 32'h40, 32'h11223344, 32'h0, 0, 1, 0);
      n_assert++; if (obs_req !== 1 || obs_wdata !== 32'h11223344 || obs_stall !== 2) begin
         n_fail++; $display("FAIL b2b store: req %0d wdata %h stall %0d want 1 11223344 2", obs_req, obs_wdata, obs_stall);
      end
      do_access(1'b1, 1'b0, SL_LB, 32'h41, 32'h0, 32'h00008000, 1, 1, 0);
      n_assert++; if (obs_stall !== 4 || obs_lv !== 1) begin
         n_fail++; $display("FAIL b2b lb: stall %0d lv %0d want 4 1", obs_stall, obs_lv);
      end
      e = exp_q.pop_front();
      n_assert++; if (obs_ld !== e) begin n_fail++; $display("FAIL b2b lb data: got %h want %h", obs_ld, e); end
      do_access(1'b1, 1'b0, SL_LHU, 32'h42, 32'h0, 32'hBEEF0000, 0, 3, 2);
      n_assert++; if (obs_stall !== 5 || obs_lv !== 1 || obs_be !== 4'b1100) begin
         n_fail++; $display("FAIL b2b lhu: stall %0d lv %0d be %b want 5 1 1100", obs_stall, obs_lv, obs_be);
      end
      e = exp_q.pop_front();
      n_assert++; if (obs_ld !== e) begin n_fail++; $display("FAIL b2b lhu data: got %h want %h", obs_ld, e); end
      last_ld = e;
   endtask

   task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
      do_access(1'b1, 1'b0, SL_LW, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1, 2);
      n_assert++; if (obs_req !== 0) begin n_fail++; $display("FAIL mis req_cycles: got %0d want 0", obs_req); end
      n_assert++; if (obs_mis !== 1) begin n_fail++; $display("FAIL mis pulses: got %0d want 1", obs_mis); end
      n_assert++; if (obs_stall !== 1) begin n_fail++; $display("FAIL mis stall: got %0d want 1", obs_stall); end
      n_assert++; if (obs_lv !== 0) begin n_fail++; $display("FAIL mis load_valid: got %0d want 0", obs_lv); end
      n_assert++; if (load_data_o !== last_ld) begin n_fail++; $display("FAIL mis load_data: got %h want %h", load_data_o, last_ld); end
      do_access(1'b1, 1'b1, SL_SH, 32'h103, 32'h1234, 32'h0, 0, 1, 2);
      n_assert++; if (obs_req !== 0 || obs_mis !== 1 || obs_stall !== 1) begin
         n_fail++; $display("FAIL mis sh: req %0d mis %0d stall %0d want 0 1 1", obs_req, obs_mis, obs_stall);
      end
`else
      do_access(1'b1, 1'b0, SL_LW, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1, 2);
      n_assert++; if (obs_req !== 1 || obs_addr !== 32'h100 || obs_be !== 4'b1111) begin
         n_fail++; $display("FAIL mask lw: req %0d addr %h be %b want 1 00000100 1111", obs_req, obs_addr, obs_be);
      end
      n_assert++; if (obs_ld !== 32'hCAFEF00D || obs_mis !== 0) begin
         n_fail++; $display("FAIL mask lw data: got %h mis %0d want cafef00d 0", obs_ld, obs_mis);
      end
      last_ld = 32'hCAFEF00D;
      do_access(1'b1, 1'b1, SL_SH, 32'h103, 32'h1234, 32'h0, 0, 1, 2);
      n_assert++; if (obs_req !== 1 || obs_be !== 4'b1100 || obs_wdata !== 32'h12341234) begin
         n_fail++; $display("FAIL mask sh: req %0d be %b wdata %h want 1 1100 12341234", obs_req, obs_be, obs_wdata);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [104:0] all_out;
      instr_valid_mem_i = 1'b1; dram_we_mem_i = 1'b0; sl_type_mem_i = SL_LW;
      alu_result_mem_i = 32'h300; rD2_mem_i = '0;
      @(posedge clk); #1;
      dram_gnt_i = 1'b1;
      @(posedge clk); #1;
      dram_gnt_i = 1'b0;
      #1;
      n_assert++; if (mem_stall_o !== 1'b1 || dram_req_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid wait_r: stall %b req %b want 1 0", mem_stall_o, dram_req_o);
      end
      rst_n = 1'b0;
      instr_valid_mem_i = 1'b0; sl_type_mem_i = '0; alu_result_mem_i = '0;
      #1;
      all_out = {dram_req_o, dram_we_o, dram_addr_o, dram_be_o, dram_wdata_o,
                 mem_stall_o, load_data_o, load_valid_o, misalign_o};
      n_assert++; if (all_out !== '0) begin n_fail++; $display("FAIL rst_mid outputs: got %h want 0", all_out); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      dram_rvalid_i = 1'b1; dram_rdata_i = 32'hFFFFFFFF;
      @(posedge clk); #1;
      dram_rvalid_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         all_out = {dram_req_o, dram_we_o, dram_addr_o, dram_be_o, dram_wdata_o,
                    mem_stall_o, load_data_o, load_valid_o, misalign_o};
         n_assert++; if (all_out !== '0) begin n_fail++; $display("FAIL rst_mid late_rvalid[%0d]: got %h want 0", k, all_out); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      instr_valid_mem_i = 1'b0; dram_we_mem_i = 1'b0; sl_type_mem_i = '0;
      alu_result_mem_i = '0; rD2_mem_i = '0;
      dram_gnt_i = 1'b0; dram_rvalid_i = 1'b0; dram_rdata_i = '0;
      last_ld = '0;
      test_reset();
      test_store();
      test_load();
      test_slow_load();
      test_noop();
      test_back_to_back();
      test_misalign();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
